// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// Universal shift register with hold, shift right, shift left and parallel
// load, optional rotation, and a saturating count of shifts performed since
// the last load or reset.
//
// Ports:
//   clk      in   1      clock, all state updates on the rising edge
//   res      in   1      asynchronous active-high reset (clears y and cnt)
//   en       in   1      clock enable, 0 holds all state
//   mode     in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   rot      in   1      1 wraps the end bit around, 0 uses the serial input
//   sin_msb  in   1      serial input entering bit WIDTH-1 on a right shift
//   sin_lsb  in   1      serial input entering bit 0 on a left shift
//   d        in   WIDTH  parallel load data
//   y        out  WIDTH  registered contents
//   sout_r   out  1      y[0]
//   sout_l   out  1      y[WIDTH-1]
//   cnt      out  CW     shifts since last load/reset, saturates at WIDTH
//   done     out  1      cnt == WIDTH
//
// WIDTH must be at least 2 so that the shift slices are non-empty.
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;

  // Count of executed shifts; it sticks at WIDTH instead of wrapping so
  // that done stays asserted until the next load or reset.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_inc = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    y_d   = y_q;
    cnt_d = cnt_q;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          y_d   = y_q;
          cnt_d = cnt_q;
        end
        MODE_RIGHT: begin
          y_d   = {(rot ? y_q[0] : sin_msb), y_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_LEFT: begin
          y_d   = {y_q[WIDTH-2:0], (rot ? y_q[WIDTH-1] : sin_lsb)};
          cnt_d = cnt_inc;
        end
        MODE_LOAD: begin
          y_d   = d;
          cnt_d = '0;
        end
        default: begin
          y_d   = y_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Reset abandons any partial shift; there is no state to resume from.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs decode registered state only, so chaining sout_r into the
  // next stage's sin_msb adds no latency and no combinational loop.
  assign y      = y_q;
  assign cnt    = cnt_q;
  assign sout_r = y_q[0];
  assign sout_l = y_q[WIDTH-1];
  assign done   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Directed bench for univ_shift_reg at WIDTH=4. A table of vectors walks
// through load, hold, enable gating, shifts, rotates and saturation; short
// hand-written sequences cover asynchronous reset and two-stage chaining.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_RIGHT = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  typedef struct {
    logic             en;
    logic [1:0]       mode;
    logic             rot;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_y;
    logic [CW-1:0]    exp_cnt;
    logic             exp_done;
  } vec_t;

  logic             clk = 1'b0;
  logic             res;
  logic             en;
  logic [1:0]       mode;
  logic             rot;
  logic             sin_msb;
  logic             sin_lsb;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_b;
  logic [WIDTH-1:0] y, y_b;
  logic             sout_r, sout_l, sout_r_b, sout_l_b;
  logic [CW-1:0]    cnt, cnt_b;
  logic             done, done_b;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .res(res), .en(en), .mode(mode), .rot(rot),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .d(d),
    .y(y), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
  );

  // Second stage fed from the first stage's right serial output.
  univ_shift_reg #(.WIDTH(WIDTH), .CW(CW)) dut_b (
    .clk(clk), .res(res), .en(en), .mode(mode), .rot(rot),
    .sin_msb(sout_r), .sin_lsb(sin_lsb), .d(d_b),
    .y(y_b), .sout_r(sout_r_b), .sout_l(sout_l_b), .cnt(cnt_b), .done(done_b)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] exp_y,
                             input logic [CW-1:0] exp_cnt, input logic exp_done);
    checkVal({tag, " y"}, 32'(y), 32'(exp_y));
    checkVal({tag, " cnt"}, 32'(cnt), 32'(exp_cnt));
    checkVal({tag, " done"}, 32'(done), 32'(exp_done));
    checkVal({tag, " sout_r"}, 32'(sout_r), 32'(exp_y[0]));
    checkVal({tag, " sout_l"}, 32'(sout_l), 32'(exp_y[WIDTH-1]));
  endtask

  // Drive inputs on the falling edge, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic r,
                               input logic sm, input logic sl, input logic [WIDTH-1:0] dd);
    @(negedge clk);
    en      = e;
    mode    = m;
    rot     = r;
    sin_msb = sm;
    sin_lsb = sl;
    d       = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en mode rot sin_msb sin_lsb d | exp_y exp_cnt exp_done
    vecs.push_back('{1'b1, M_LOAD,  1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_HOLD,  1'b0, 1'b1, 1'b1, 4'b0000, 4'b1001, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_HOLD,  1'b1, 1'b0, 1'b1, 4'b1111, 4'b1001, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_HOLD,  1'b0, 1'b1, 1'b0, 4'b0110, 4'b1001, 3'd0, 1'b0});
    vecs.push_back('{1'b0, M_LOAD,  1'b0, 1'b0, 1'b0, 4'b0000, 4'b1001, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_LOAD,  1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1101, 3'd1, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110, 3'd2, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd3, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd4, 1'b1});
    vecs.push_back('{1'b1, M_LOAD,  1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_LEFT,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0});
    vecs.push_back('{1'b1, M_LEFT,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 3'd2, 1'b0});
    vecs.push_back('{1'b1, M_LEFT,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 3'd3, 1'b0});
    vecs.push_back('{1'b1, M_LEFT,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd4, 1'b1});
    vecs.push_back('{1'b1, M_LEFT,  1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd4, 1'b1});
    vecs.push_back('{1'b1, M_LOAD,  1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 3'd1, 1'b0});
    vecs.push_back('{1'b0, M_RIGHT, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 3'd1, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd2, 1'b0});
    vecs.push_back('{1'b1, M_RIGHT, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 3'd3, 1'b0});
    vecs.push_back('{1'b1, M_LEFT,  1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 3'd4, 1'b1});
    vecs.push_back('{1'b1, M_LEFT,  1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 3'd4, 1'b1});
    vecs.push_back('{1'b1, M_LOAD,  1'b1, 1'b1, 1'b1, 4'b0101, 4'b0101, 3'd0, 1'b0});
    vecs.push_back('{1'b1, M_LEFT,  1'b1, 1'b1, 1'b0, 4'b0000, 4'b1010, 3'd1, 1'b0});

    res     = 1'b1;
    en      = 1'b0;
    mode    = M_HOLD;
    rot     = 1'b0;
    sin_msb = 1'b0;
    sin_lsb = 1'b0;
    d       = '0;
    d_b     = '0;
    #12;
    checkOutput("reset", 4'b0000, 3'd0, 1'b0);
    @(negedge clk);
    res = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].rot, vecs[i].sin_msb,
                    vecs[i].sin_lsb, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_cnt, vecs[i].exp_done);
    end

    // Asynchronous reset mid-cycle during a partial shift.
    applyStimulus(1'b1, M_LOAD, 1'b0, 1'b0, 1'b0, 4'b1011);
    checkOutput("preres load", 4'b1011, 3'd0, 1'b0);
    applyStimulus(1'b1, M_RIGHT, 1'b0, 1'b1, 1'b0, 4'b0000);
    checkOutput("preres shift", 4'b1101, 3'd1, 1'b0);
    #2;
    res = 1'b1;
    #1;
    checkOutput("async res", 4'b0000, 3'd0, 1'b0);
    mode = M_LOAD;
    d    = 4'b1111;
    @(posedge clk);
    #1;
    checkOutput("res held", 4'b0000, 3'd0, 1'b0);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first op", 4'b1111, 3'd0, 1'b0);

    // Two-stage chain: A=1100, B=0000, four right shifts with zeros in.
    @(negedge clk);
    d_b = 4'b0000;
    applyStimulus(1'b1, M_LOAD, 1'b0, 1'b0, 1'b0, 4'b1100);
    checkVal("chain load A", 32'(y), 32'(4'b1100));
    checkVal("chain load B", 32'(y_b), 32'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, M_RIGHT, 1'b0, 1'b0, 1'b0, 4'b0000);
    end
    checkVal("chain mid A", 32'(y), 32'(4'b0001));
    checkVal("chain mid B", 32'(y_b), 32'(4'b1000));
    applyStimulus(1'b1, M_RIGHT, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkVal("chain end A", 32'(y), 32'(4'b0000));
    checkVal("chain end B", 32'(y_b), 32'(4'b1100));
    checkVal("chain done B", 32'(done_b), 32'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter: CW, default $clog2(WIDTH+1), shift-counter width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 res  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  clock enable; 0 = all state holds.
REQ-006 mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 rot  input  1  1 = rotate (wrap end bit), 0 = shift in the serial input.
REQ-008 sin_msb  input  1  serial input entering bit WIDTH-1 on a right shift.
REQ-009 sin_lsb  input  1  serial input entering bit 0 on a left shift.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 y  output  WIDTH  register contents (registered).
REQ-012 sout_r  output  1  serial out, right side; equals y[0].
REQ-013 sout_l  output  1  serial out, left side; equals y[WIDTH-1].
REQ-014 cnt  output  CW  shifts performed since last load or reset; saturates at WIDTH.
REQ-015 done  output  1  high when cnt == WIDTH (full word shifted out).

Function
REQ-016 Operation executes only on a rising clk edge with en=1 and res=0; en=0 holds y and cnt regardless of mode.
REQ-017 mode 00: y and cnt unchanged.
REQ-018 mode 11: y <= d and cnt <= 0 on the same edge; rot ignored.
REQ-019 mode 01, rot=0: y <= {sin_msb, y[WIDTH-1:1]}.
REQ-020 mode 01, rot=1: y <= {y[0], y[WIDTH-1:1]}; sin_msb ignored.
REQ-021 mode 10, rot=0: y <= {y[WIDTH-2:0], sin_lsb}.
REQ-022 mode 10, rot=1: y <= {y[WIDTH-2:0], y[WIDTH-1]}; sin_lsb ignored.
REQ-023 Each executed shift or rotate (mode 01 or 10) increments cnt by 1; cnt stops at WIDTH and never wraps.
REQ-024 Direction changes between shifts do not reset cnt; only load or reset clear it.
REQ-025 sout_r, sout_l, done are combinational decodes of registered state: no input-to-output combinational path, valid in the same cycle as y.
REQ-026 Load latency: d visible on y one clock after the loading edge; shift latency likewise one clock.
REQ-027 Serial chaining: sout_r of one instance feeding sin_msb of the next forms a 2*WIDTH right-shift chain with no added latency.

Reset
REQ-028 res=1 forces y=0 and cnt=0 immediately, without waiting for clk; hence sout_r=0, sout_l=0, done=0.
REQ-029 res held high overrides en and mode; an operation in progress (partial shift) is abandoned, with no recovery state.
REQ-030 First operation executes on the first rising edge with res=0.

Verification (WIDTH=4)
REQ-031 res=1 pulse mid-cycle with y=1011 -> y=0000, cnt=0 before the next edge; no operation while res=1.
REQ-032 mode=11, d=1001, en=1, one edge -> y=1001, cnt=0; then mode=00 for 3 edges -> y stays 1001.
REQ-033 Load 1010, mode=01, rot=0, sin_msb=1, 4 edges -> y = 1101, 1110, 1111, 1111; sout_r = 0,1,0,1 pre-edge; cnt 1..4; done=1 after the 4th edge.
REQ-034 Load 1000, mode=10, rot=1, 5 edges -> y = 0001, 0010, 0100, 1000, 0001; cnt saturates at 4; done stays 1.
REQ-035 Load 0110, mode=01 with en toggling 1,0,1 -> y = 0011, 0011, 0001 (sin_msb=0); cnt 1,1,2.
REQ-036 Two instances chained (sout_r -> sin_msb), A loaded 1100, B loaded 0000, 4 right shifts with A.sin_msb=0 -> A=0000, B=1100.
